// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/response bundle between the execute stage and the divider
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 flag_unsigned_i;
    logic [WIDTH-1:0]     operand1_i;
    logic [WIDTH-1:0]     operand2_i;
    logic                 cancel_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 done_o;
    logic                 busy_o;

    modport master (
        output start_i, flag_unsigned_i, operand1_i, operand2_i, cancel_i,
        input  result_o, done_o, busy_o
    );

    modport slave (
        input  start_i, flag_unsigned_i, operand1_i, operand2_i, cancel_i,
        output result_o, done_o, busy_o
    );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring signed/unsigned divider returning {remainder, quotient}
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clock_i,
    input  logic          reset_i,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, SIGN} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem, dvd, dvsr, op1;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] result;
    logic               done;

    logic               accept, sign1, sign2, last_step, trial_ok;
    logic [WIDTH-1:0]   mag1, mag2, rem_next, q_fix, r_fix;
    logic [WIDTH:0]     rem_sh;

    assign accept    = bus.start_i && !bus.cancel_i;
    assign sign1     = !bus.flag_unsigned_i && bus.operand1_i[WIDTH-1];
    assign sign2     = !bus.flag_unsigned_i && bus.operand2_i[WIDTH-1];
    assign mag1      = sign1 ? (~bus.operand1_i + WIDTH'(1)) : bus.operand1_i;
    assign mag2      = sign2 ? (~bus.operand2_i + WIDTH'(1)) : bus.operand2_i;
    assign last_step = (count == CW'(WIDTH - 1));

    // The shifted remainder can exceed WIDTH bits, so compare on WIDTH+1 bits;
    // when it fits the divisor the low WIDTH bits of the difference are exact.
    assign rem_sh   = {rem, dvd[WIDTH-1]};
    assign trial_ok = (rem_sh >= {1'b0, dvsr});
    assign rem_next = rem_sh[WIDTH-1:0] - dvsr;

    assign q_fix = neg_q ? (~dvd + WIDTH'(1)) : dvd;
    assign r_fix = neg_r ? (~rem + WIDTH'(1)) : rem;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_step) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.cancel_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count  <= '0;
            rem    <= '0;
            dvd    <= '0;
            dvsr   <= '0;
            op1    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op1   <= bus.operand1_i;
                        dvsr  <= mag2;
                        dvd   <= mag1;
                        rem   <= '0;
                        count <= '0;
                        neg_q <= sign1 ^ sign2;
                        neg_r <= sign1;
                    end
                end
                BUSY: begin
                    if (!bus.cancel_i) begin
                        rem   <= trial_ok ? rem_next : rem_sh[WIDTH-1:0];
                        dvd   <= {dvd[WIDTH-2:0], trial_ok};
                        count <= count + CW'(1);
                    end
                end
                SIGN: begin
                    if (!bus.cancel_i) begin
                        // A zero divisor leaves the raw dividend as remainder, quotient all ones.
                        if (dvsr == '0) begin
                            result <= {op1, {WIDTH{1'b1}}};
                        end else begin
                            result <= {r_fix, q_fix};
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.done_o   = done;
    assign bus.busy_o   = (state != IDLE);
endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for iter_divider against an arithmetic reference model
module tb_iter_divider;
    localparam int W = 32;

    typedef struct {
        logic [63:0] res;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_divider_if #(.WIDTH(W)) bus ();
    iter_divider #(.WIDTH(W)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic u, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, uq, ur;
        longint sa, sbv, sq, sr;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (u) begin
            ua = 64'(a);
            ub = 64'(b);
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
        end
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sq  = sa / sbv;
        sr  = sa % sbv;
        return {sr[31:0], sq[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            check("done_pulse_width", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done_o=1 result %h, expected no pending request", bus.result_o);
            end else begin
                mon_e = sb.pop_front();
                check("result", bus.result_o, mon_e.res);
                check("latency", 64'(cyc - mon_e.acc), 64'd33);
            end
        end
        prev_done <= bus.done_o;
    end

    task automatic issue(input logic u, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp, output int acc);
        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.flag_unsigned_i = u;
        bus.operand1_i      = a;
        bus.operand2_i      = b;
        @(posedge clk);
        #1 acc = cyc;
        if (push) sb.push_back('{exp, acc});
        @(negedge clk);
        check("busy_after_accept", 64'(bus.busy_o), 64'd1);
        bus.start_i         = 1'b0;
        bus.flag_unsigned_i = 1'($urandom);
        bus.operand1_i      = $urandom;
        bus.operand2_i      = $urandom;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending results after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    logic        dir_u [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] dir_a [8] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF};
    logic [31:0] dir_b [8] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFE};
    logic [63:0] dir_r [8] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                               64'h00000005_FFFFFFFF, 64'h00000000_80000000, 64'h00000000_FFFFFFFF,
                               64'hFFFFFFF9_FFFFFFFF, 64'h00000001_00000001};

    initial begin
        int          acc, acc1;
        logic        u;
        logic [31:0] a, b;
        logic [63:0] exp1, exp2;

        rst                 = 1'b1;
        bus.start_i         = 1'b0;
        bus.flag_unsigned_i = 1'b0;
        bus.operand1_i      = '0;
        bus.operand2_i      = '0;
        bus.cancel_i        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result", bus.result_o, 64'd0);
        check("reset_done", 64'(bus.done_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(dir_u[i], dir_a[i], dir_b[i], 1'b1, dir_r[i], acc);
            drain(60);
        end

        // Cancel mid-run after a completed 100/7.
        issue(1'b1, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, acc);
        drain(60);
        issue(1'b1, 32'd50, 32'd3, 1'b0, 64'd0, acc);
        repeat (9) @(negedge clk);
        bus.cancel_i = 1'b1;
        @(negedge clk);
        bus.cancel_i = 1'b0;
        check("cancel_busy", 64'(bus.busy_o), 64'd0);
        check("cancel_done", 64'(bus.done_o), 64'd0);
        check("cancel_result_held", bus.result_o, 64'h00000002_0000000E);
        repeat (40) @(negedge clk);
        check("cancel_result_still_held", bus.result_o, 64'h00000002_0000000E);
        issue(1'b1, 32'd9, 32'd4, 1'b1, 64'h00000001_00000002, acc);
        drain(60);

        // start_i held across two back-to-back divisions.
        exp1 = 64'h00000000_00000064;
        exp2 = 64'h00000001_00000064;
        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.flag_unsigned_i = 1'b1;
        bus.operand1_i      = 32'd1000;
        bus.operand2_i      = 32'd10;
        @(posedge clk);
        #1 acc1 = cyc;
        sb.push_back('{exp1, acc1});
        sb.push_back('{exp2, acc1 + 34});
        @(negedge clk);
        bus.operand1_i = 32'd1001;
        for (int n = 0; n < 120 && sb.size() != 0; n++) begin
            @(negedge clk);
            if (cyc == acc1 + 34) bus.start_i = 1'b0;
            if (cyc >= acc1 + 34 && cyc <= acc1 + 66) check("hold_first_result", bus.result_o, exp1);
        end
        bus.start_i = 1'b0;
        drain(10);

        // Reset in the middle of a division.
        issue(1'b1, 32'd12345, 32'd67, 1'b0, 64'd0, acc);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_result", bus.result_o, 64'd0);
        check("midreset_done", 64'(bus.done_o), 64'd0);
        check("midreset_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        issue(1'b0, 32'hFFFFFF00, 32'd16, 1'b1, model(1'b0, 32'hFFFFFF00, 32'd16), acc);
        drain(60);

        for (int i = 0; i < 40; i++) begin
            u = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2, 3: b = 32'($urandom_range(1, 15));
                4:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            issue(u, a, b, 1'b1, model(u, a, b), acc);
            drain(60);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
